ddr3_pattern_tester: RTL

- Parametrised DDR3 self-test traffic source and checker on the user FIFO side of the DDR3 controller.
- After calibration it writes TEST_LEN pattern words into the write FIFO and enables memory read-back.
- It then drains the read FIFO and compares every returned word against the regenerated pattern.
- It reports pass/fail, a saturating error count, the first failing index and a read timeout.

---
 rtl/ddr3_pattern_tester.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ddr3_pattern_tester.sv
// ddr3_pattern_tester
// Self-test traffic source and checker that sits on the user FIFO side of a
// DDR3 controller. When a run starts it waits for calibration, then writes
// TEST_LEN pattern words into the write FIFO. Next it lets the controller
// read memory back, drains the read FIFO, and compares every returned word
// against the regenerated pattern.
//
// Ports:
//   clk, rst_n          FIFO user clock, asynchronous active-low reset
//   calib_done          DDR3 calibration complete
//   start               rising edge launches a run (only from IDLE/DONE)
//   mode                0 = incrementing, 1 = checkerboard-XOR; latched at start
//   inject_err          (DDR3_PATTERN_ERR_INJECT_EN only) rising edge during WRITE
//                       inverts bit 0 of the next accepted write word
//   wr_full/wr_en/wr_data          write FIFO interface
//   rd_valid/rd_data/rd_en         read FIFO interface; rd_data valid 1 cycle after rd_en
//   rd_mem_enable       permits the controller to read DDR3
//   busy, done, pass, timeout      run status
//   err_cnt             saturating mismatch count
//   first_err_idx       index of the first mismatch
//
// Optional feature macro: DDR3_PATTERN_ERR_INJECT_EN
module ddr3_pattern_tester #(
   parameter int DATA_WIDTH = 16,
   parameter int TEST_LEN   = 1300,
   parameter int IDX_WIDTH  = 16,
   parameter int ERR_WIDTH  = 16,
   parameter int SEED       = 0,
   parameter int TIMEOUT    = 65535
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  calib_done,
   input  logic                  start,
   input  logic                  mode,
`ifdef DDR3_PATTERN_ERR_INJECT_EN
   input  logic                  inject_err,
`endif
   input  logic                  wr_full,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_valid,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_en,
   output logic                  rd_mem_enable,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [ERR_WIDTH-1:0]  err_cnt,
   output logic [IDX_WIDTH-1:0]  first_err_idx
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(TEST_LEN - 1);
   localparam logic [IDX_WIDTH-1:0] LEN_IDX  = IDX_WIDTH'(TEST_LEN);
   localparam logic [TW-1:0]        TO_MAX   = TW'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, WAIT_CAL, WRITE, READ, DONE} state_t;

   state_t                state, nstate;
   logic                  start_q, start_rise, run_clr;
   logic                  mode_q;
   logic [IDX_WIDTH-1:0]  wr_idx, iss_cnt, chk_idx;
   logic                  cmp_stb, mismatch, to_hit;
   logic [TW-1:0]         to_cnt;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [ERR_WIDTH-1:0]  err_next;

   function automatic logic [DATA_WIDTH-1:0] pat(input logic [IDX_WIDTH-1:0] i,
                                                 input logic m);
      logic [DATA_WIDTH-1:0] base, c;
      base = DATA_WIDTH'(SEED) + DATA_WIDTH'(i);
      c    = i[0] ? {DATA_WIDTH/2{2'b10}} : {DATA_WIDTH/2{2'b01}};
      return m ? (base ^ c) : base;
   endfunction

   assign start_rise = start & ~start_q;
   assign run_clr    = start_rise && (state == IDLE || state == DONE);
   assign busy       = (state == WAIT_CAL) || (state == WRITE) || (state == READ);
   assign done       = (state == DONE);

   // A compare strobe only means something while reading.
   assign mismatch = cmp_stb && (state == READ) && (rd_data != pat(chk_idx, mode_q));
   assign err_next = (mismatch && err_cnt != '1) ? err_cnt + ERR_WIDTH'(1) : err_cnt;

   always_comb begin
      nstate = state;
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      to_hit = 1'b0;
      case (state)
         IDLE, DONE: if (start_rise) nstate = WAIT_CAL;
         WAIT_CAL:   if (calib_done) nstate = WRITE;
         WRITE: begin
            wr_en = !wr_full;
            if (wr_en && wr_idx == LAST_IDX) nstate = READ;
         end
         READ: begin
            rd_en = rd_valid && (iss_cnt < LEN_IDX);
            // Finishing the last compare wins over a coincident timeout.
            if (cmp_stb && chk_idx == LAST_IDX) nstate = DONE;
            else if (to_cnt == TO_MAX) begin
               to_hit = 1'b1;
               nstate = DONE;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         start_q       <= 1'b0;
         mode_q        <= 1'b0;
         wr_idx        <= '0;
         iss_cnt       <= '0;
         chk_idx       <= '0;
         cmp_stb       <= 1'b0;
         to_cnt        <= '0;
         wr_data_q     <= '0;
         rd_mem_enable <= 1'b0;
         pass          <= 1'b0;
         timeout       <= 1'b0;
         err_cnt       <= '0;
         first_err_idx <= '0;
      end else begin
         state         <= nstate;
         start_q       <= start;
         rd_mem_enable <= (nstate == READ);
         cmp_stb       <= rd_en;
         if (run_clr) begin
            mode_q        <= mode;
            wr_idx        <= '0;
            iss_cnt       <= '0;
            chk_idx       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
         end
         // wr_data is registered, so it is preloaded with the word that will
         // be presented next: f(0) while waiting, f(idx+1) after each accept.
         if (state == WAIT_CAL) wr_data_q <= pat('0, mode_q);
         if (wr_en) begin
            wr_idx    <= wr_idx + IDX_WIDTH'(1);
            wr_data_q <= pat(wr_idx + IDX_WIDTH'(1), mode_q);
         end
         if (rd_en) iss_cnt <= iss_cnt + IDX_WIDTH'(1);
         if (cmp_stb && state == READ) begin
            chk_idx <= chk_idx + IDX_WIDTH'(1);
            err_cnt <= err_next;
            if (mismatch && err_cnt == '0) first_err_idx <= chk_idx;
         end
         if (state != READ || rd_valid) to_cnt <= '0;
         else if (to_cnt != TO_MAX)     to_cnt <= to_cnt + TW'(1);
         if (to_hit) timeout <= 1'b1;
         if (nstate == DONE && state != DONE) pass <= (err_next == '0) && !to_hit;
      end
   end

`ifdef DDR3_PATTERN_ERR_INJECT_EN
   logic inj_q, inj_arm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inj_q   <= 1'b0;
         inj_arm <= 1'b0;
      end else begin
         inj_q <= inject_err;
         if (run_clr)                                   inj_arm <= 1'b0;
         else if (wr_en && inj_arm)                     inj_arm <= 1'b0;
         else if (state == WRITE && inject_err && !inj_q) inj_arm <= 1'b1;
      end
   end

   // The corruption rides on the presented word until it is accepted.
   assign wr_data = wr_data_q ^ {{(DATA_WIDTH-1){1'b0}}, inj_arm && (state == WRITE)};
`else
   assign wr_data = wr_data_q;
`endif

endmodule
